// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Bit-serial shift-add multiply and restoring divide, one op at a time.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic           accept;
  logic           a_sgn;
  logic           b_sgn;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic           b_zero;
  logic           a_min;
  logic           b_ones;
  logic           ovf;
  logic           special;
  logic [W-1:0]   spec_res;

  logic [2:0]     op_q;
  logic           neg_q;
  logic           negr_q;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic           last;

  logic [W:0]     sum;
  logic [W:0]     sh;
  logic [W:0]     diff;
  logic [2*W-1:0] mul_nx;
  logic [2*W-1:0] div_nx;
  logic [2*W-1:0] acc_nx;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   fin;

  assign accept = valid_i & ready_o & ~flush_i;
  assign last   = (cnt == CNT_ONE);

  // Operand sign, magnitude and special-case decode at accept.
  always_comb begin
    a_sgn  = a_i[W-1] &
             (op_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
    b_sgn  = b_i[W-1] &
             (op_i inside {3'b000, 3'b001, 3'b100, 3'b110});
    a_mag  = a_sgn ? -a_i : a_i;
    b_mag  = b_sgn ? -b_i : b_i;
    b_zero = (b_i == '0);
    a_min  = (a_i == {1'b1, {(W-1){1'b0}}});
    b_ones = &b_i;
    ovf    = ~op_i[0] & a_min & b_ones;
    special = op_i[2] & (b_zero | ovf);
    if (b_zero)
      spec_res = op_i[1] ? a_i : '1;
    else
      spec_res = op_i[1] ? '0 : a_i;
  end

  // One shift-add or restoring-divide step on the shared accumulator.
  always_comb begin
    sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx = {sum, acc[W-1:1]};
    sh     = acc[2*W-1:W-1];
    diff   = sh - {1'b0, opnd};
    div_nx = diff[W] ? {sh[W-1:0], acc[W-2:0], 1'b0}
                     : {diff[W-1:0], acc[W-2:0], 1'b1};
    acc_nx = op_q[2] ? div_nx : mul_nx;
  end

  // Sign fix-up and result selection after the final step.
  always_comb begin
    prod_s = neg_q ? -acc_nx : acc_nx;
    quo    = neg_q ? -acc_nx[W-1:0] : acc_nx[W-1:0];
    rem    = negr_q ? -acc_nx[2*W-1:W] : acc_nx[2*W-1:W];
    fin    = '0;
    unique case (op_q)
      3'b000:                 fin = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[2*W-1:W];
      3'b100, 3'b101:         fin = quo;
      3'b110, 3'b111:         fin = rem;
      default:                fin = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; flush aborts CALC and blocks a new accept.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) state_nx = special ? DONE : CALC;
        else        state_nx = IDLE;
      end
      CALC: begin
        if (flush_i)   state_nx = IDLE;
        else if (last) state_nx = DONE;
        else           state_nx = CALC;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decode only from the state register.
  always_comb begin
    ready_o = (state != CALC);
    busy_o  = (state == CALC);
    done_o  = (state == DONE);
  end

  // Datapath: capture at accept, iterate in CALC, write result at the end.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      result_o <= '0;
    end else if (accept) begin
      op_q   <= op_i;
      neg_q  <= a_sgn ^ b_sgn;
      negr_q <= a_sgn;
      cnt    <= CNT_INIT;
      acc    <= {{W{1'b0}}, a_mag};
      opnd   <= b_mag;
      if (special) result_o <= spec_res;
    end else if (state == CALC && !flush_i) begin
      acc <= acc_nx;
      cnt <= cnt - CNT_ONE;
      if (last) result_o <= fin;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and model-checked bench for muldiv_unit.
// Expected results queue at issue and are compared at done_o.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int          tests;
  int          fails;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;
  logic [31:0] dummy;
  bit          seen;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] s32a, s32b;
    logic               ov;
    logic [31:0]        r;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    s32a = a;
    s32b = b;
    ov   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r    = '0;
    case (op)
      3'd0: begin up = ua * ub; r = up[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ov ? a : s32a / s32b;
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ov ? 32'h0 : s32a % s32b;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Called at a negedge; request is accepted at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    chk("ready_at_issue", {31'b0, ready_o}, 32'd1);
    exp_q.push_back(exp);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    op_i    = 3'($urandom_range(7));
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic wait_done(input int lat, input string tag,
                           input bit special);
    int          cyc;
    bit          bsy;
    logic [31:0] e;
    cyc = 1;
    bsy = 1'b0;
    while (done_o !== 1'b1 && cyc < 100) begin
      bsy |= busy_o;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, {31'b0, done_o}, 32'd1);
    chk({tag, "_lat"}, cyc, lat);
    e = exp_q.pop_front();
    last_exp = e;
    chk({tag, "_res"}, result_o, e);
    if (special) chk({tag, "_nobusy"}, {31'b0, bsy}, 32'd0);
    else         chk({tag, "_busy"}, {31'b0, bsy}, 32'd1);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp,
                     input int lat, input string tag);
    @(negedge clk);
    issue(op, a, b, exp);
    wait_done(lat, tag, lat == 1);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    rst_ni = 1'b1;

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run(3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "mulh");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, "mulhsu");
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
    run(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    run(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");
    run(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    run(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          lat;
      op = 3'($urandom_range(7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      lat = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF))) ? 1 : 33;
      run(op, a, b, ref_op(op, a, b), lat, "rand");
    end

    run(3'd1, 32'h1234_5678, 32'h8765_4321,
        ref_op(3'd1, 32'h1234_5678, 32'h8765_4321), 33, "mulh_mixed");

    // Flush in CALC cycle 10.
    @(negedge clk);
    issue(3'd0, 32'd3, 32'd5, 32'd15);
    repeat (9) @(negedge clk);
    chk("flush_busy_before", {31'b0, busy_o}, 32'd1);
    chk("flush_ready_before", {31'b0, ready_o}, 32'd0);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    dummy = exp_q.pop_front();
    chk("flush_ready", {31'b0, ready_o}, 32'd1);
    chk("flush_busy", {31'b0, busy_o}, 32'd0);
    chk("flush_result_held", result_o, last_exp);
    seen = 1'b0;
    repeat (40) begin
      seen |= done_o;
      @(negedge clk);
    end
    chk("flush_no_done", {31'b0, seen}, 32'd0);

    // A flushed would-be accept is dropped.
    flush_i = 1'b1;
    valid_i = 1'b1;
    op_i    = 3'd0;
    a_i     = 32'd2;
    b_i     = 32'd2;
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_drop_busy", {31'b0, busy_o}, 32'd0);
    chk("flush_drop_done", {31'b0, done_o}, 32'd0);

    run(3'd0, 32'd6, 32'd7, 32'd42, 33, "mul_after_flush");

    // Reset for one edge mid-CALC.
    @(negedge clk);
    issue(3'd0, 32'd9, 32'd9, 32'd81);
    repeat (4) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    dummy = exp_q.pop_front();
    chk("midrst_ready", {31'b0, ready_o}, 32'd1);
    chk("midrst_busy", {31'b0, busy_o}, 32'd0);
    chk("midrst_done", {31'b0, done_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      seen |= done_o;
      @(negedge clk);
    end
    chk("midrst_no_done", {31'b0, seen}, 32'd0);

    // Back-to-back accept in the DONE cycle.
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    wait_done(33, "b2b_first", 1'b0);
    issue(3'd7, 32'd100, 32'd7, 32'd2);
    wait_done(33, "b2b_second", 1'b0);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    wait_done(33, "b2b_third", 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit implementing the RV32M operation set for the processor core, parametrised in data width. Sits alongside the ALU in the execute stage. Accepts one operation at a time through a valid/ready handshake, computes it with a bit-serial shift-add or restoring-divide datapath, and returns the result with a one-cycle done pulse. The surrounding control stalls the core while the unit is busy.

## Interface
- DATA_WIDTH, 32: operand and result width in bits; even and ≥ 4.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- valid_i  in  1  request valid; sampled only while ready_o = 1.
- ready_o  out  1  unit can accept a request; equals (state != CALC).
- op_i  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  in  DATA_WIDTH  operand rs1.
- b_i  in  DATA_WIDTH  operand rs2.
- flush_i  in  1  abort any in-flight operation.
- busy_o  out  1  high while state = CALC.
- done_o  out  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  out  DATA_WIDTH  registered result; held until the next accepted request completes.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE/DONE + accept (valid_i & ready_o & !flush_i):
    - Latch op_i, |a|, |b|, sign flags, and iteration count = DATA_WIDTH.
    - Go to CALC.
    - Special cases go directly to DONE instead (see below).
  - CALC: one iteration per cycle. When the counter reaches 0, write result_o and go to DONE.
  - DONE: done_o = 1 for this single cycle. Go to IDLE unless a new request is accepted in the same cycle.
- Multiply:
  - Unsigned shift-add into a 2·DATA_WIDTH product.
  - Sign handling:
    - MUL and MULH: both operands signed.
    - MULHSU: a_i signed, b_i unsigned.
    - MULHU: both unsigned.
  - Negate the full 2·DATA_WIDTH product when the operand signs differ, then select the result:
    - MUL: low half.
    - MULH, MULHSU, MULHU: high half.
- Divide:
  - Restoring division on magnitudes.
  - DIV/REM are signed: the quotient sign is the XOR of the operand signs, and the remainder takes the sign of the dividend.
  - DIVU/REMU are unsigned.
- Special cases (decided at accept, DONE on the next edge, zero CALC cycles):
  - b_i = 0: DIV/DIVU give all ones; REM/REMU give a_i.
  - Signed overflow (a_i = most-negative, b_i = all ones): DIV gives most-negative; REM gives 0.
- flush_i:
  - In CALC: go to IDLE next edge, no done_o, result_o unchanged.
  - Same cycle as a would-be accept: flush wins and the request is dropped.
  - In DONE: done_o still pulses this cycle (the edge has already been reached).
- rst_ni = 0 at any edge, including mid-CALC: state IDLE, result_o 0, done_o 0, busy_o 0, internal registers 0.

## Timing
- After reset: ready_o = 1, busy_o = 0, done_o = 0, result_o = 0.
- Accept at edge k, normal case:
  - busy_o high during cycles k+1 … k+DATA_WIDTH.
  - done_o high in cycle k+DATA_WIDTH+1.
  - Latency is DATA_WIDTH+1 cycles; 33 for the default width.
- Accept at edge k, special case: done_o high in cycle k+1.
- Back-to-back: a request accepted during the DONE cycle begins CALC at the next edge, giving a throughput of one operation per DATA_WIDTH+1 cycles.
- Operands are captured at accept; changes on a_i, b_i, and op_i during CALC have no effect.
- No combinational path from inputs to result_o or done_o. ready_o and busy_o decode only from the state register.

## Test plan
- Reset, then MUL a=7, b=−3 (0xFFFFFFFD) -> done_o at accept+33, result_o = 0xFFFFFFEB. Repeat with MULH -> 0xFFFFFFFF, and MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF (−1), b=2 -> 0xFFFFFFFF. DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. Both with done_o one cycle after accept and busy_o never high.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Both 1-cycle latency.
- flush_i in CALC cycle 10 -> no done_o; ready_o = 1 next cycle; result_o retains its previous value. A new MUL 6×7 then returns 42 at full latency.
- rst_ni low for one edge mid-CALC -> all outputs 0 and ready_o = 1 next cycle. Back-to-back accept in the DONE cycle -> second done_o exactly 33 cycles after the first.
